// File: rtl/hazard_pkg.sv
// Shared types, opcode constants and instruction field extractors for the hazard controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [3:0]  LOAD_OP_DEF = 4'hB;
    localparam logic [15:0] NOP_INSTR   = 16'h0000;

    // Generic right-aligned field extract; callers pass the field's lsb position and width.
    function automatic logic [7:0] get_field(input logic [31:0] instr,
                                             input int unsigned lsb,
                                             input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return 8'((instr >> lsb) & mask);
    endfunction

    // Opcode occupies the top op_w bits of the instruction.
    function automatic logic [7:0] get_op(input logic [31:0] instr,
                                          input int unsigned instr_w,
                                          input int unsigned op_w);
        return get_field(instr, instr_w - op_w, op_w);
    endfunction

    // Destination register sits directly below the opcode.
    function automatic logic [7:0] get_rd(input logic [31:0] instr,
                                          input int unsigned instr_w,
                                          input int unsigned op_w,
                                          input int unsigned reg_w);
        return get_field(instr, instr_w - op_w - reg_w, reg_w);
    endfunction

    // First source register follows rd.
    function automatic logic [7:0] get_rs(input logic [31:0] instr,
                                          input int unsigned instr_w,
                                          input int unsigned op_w,
                                          input int unsigned reg_w);
        return get_field(instr, instr_w - op_w - 2 * reg_w, reg_w);
    endfunction

    // Second source register follows rs.
    function automatic logic [7:0] get_rt(input logic [31:0] instr,
                                          input int unsigned instr_w,
                                          input int unsigned op_w,
                                          input int unsigned reg_w);
        return get_field(instr, instr_w - op_w - 3 * reg_w, reg_w);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of ID/EX instruction inputs and pipeline control outputs for the hazard controller.
// Latency: n/a (wiring only).
// Backpressure: pc_enable/ifid_enable low hold the front end of the pipe.
interface hazard_stall_ctrl_if #(
    parameter int INSTR_W = 16,
    parameter int PERF_W  = 16
);
    logic [INSTR_W-1:0] instr_id;
    logic               id_valid;
    logic [INSTR_W-1:0] instr_ex;
    logic               ex_valid;
    logic               branch_taken_ex;
    logic               perf_clr;

    logic               pc_enable;
    logic               ifid_enable;
    logic               idex_bubble;
    logic               ifid_flush;
    logic               stall_active;
    logic [PERF_W-1:0]  stall_cycles;

    // Datapath side: presents instructions, consumes control.
    modport master (
        output instr_id, id_valid, instr_ex, ex_valid, branch_taken_ex, perf_clr,
        input  pc_enable, ifid_enable, idex_bubble, ifid_flush, stall_active, stall_cycles
    );

    // Controller side.
    modport slave (
        input  instr_id, id_valid, instr_ex, ex_valid, branch_taken_ex, perf_clr,
        output pc_enable, ifid_enable, idex_bubble, ifid_flush, stall_active, stall_cycles
    );
endinterface

// File: rtl/hazard_perf_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, clr has priority over inc.
// Latency: count reflects an inc/clr one clock after it is presented.
// Backpressure: none; inc is sampled every cycle.
module hazard_perf_counter #(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [PERF_W-1:0] count
);

    localparam logic [PERF_W-1:0] ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    // Clear beats increment; increment stops once the counter is saturated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard stall and taken-branch flush controller between ID and EX.
// Latency: control outputs are combinational (zero cycles); a load-use hazard stalls LOAD_LAT cycles.
// Backpressure: holds PC and IF/ID and bubbles ID/EX while stalling; branch flush overrides stall.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int              INSTR_W     = 16,
    parameter int              OP_W        = 4,
    parameter int              REG_W       = 4,
    parameter logic [OP_W-1:0] LOAD_OP     = LOAD_OP_DEF,
    parameter int              LOAD_LAT    = 1,   // legal 1..7, cnt is 3 bits
    parameter bit              ZERO_REG_EN = 1'b1,
    parameter int              PERF_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_stall_ctrl_if.slave bus
);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;

    logic [7:0]  op_ex, rd_ex, rs_id, rt_id;
    logic        is_load_ex;
    logic        reg_match;
    logic        zero_dest;
    logic        hazard;

    logic        pc_enable;
    logic        ifid_enable;
    logic        idex_bubble;
    logic        ifid_flush;
    logic        stall_active;

    // Decode the fields that matter for the load-use check.
    always_comb begin
        op_ex = get_op(32'(bus.instr_ex), INSTR_W, OP_W);
        rd_ex = get_rd(32'(bus.instr_ex), INSTR_W, OP_W, REG_W);
        rs_id = get_rs(32'(bus.instr_id), INSTR_W, OP_W, REG_W);
        rt_id = get_rt(32'(bus.instr_id), INSTR_W, OP_W, REG_W);
    end

    // A valid load in EX whose destination feeds a valid ID instruction; r0 writes are harmless.
    always_comb begin
        is_load_ex = (op_ex == 8'(LOAD_OP));
        reg_match  = (rd_ex == rs_id) || (rd_ex == rt_id);
        zero_dest  = ZERO_REG_EN && (rd_ex == 8'd0);
        hazard     = bus.ex_valid && bus.id_valid && is_load_ex && reg_match && !zero_dest;
    end

    // Next state and control outputs; reset, then branch, then stall in priority order.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_enable    = 1'b1;
        ifid_enable  = 1'b1;
        idex_bubble  = 1'b0;
        ifid_flush   = 1'b0;
        stall_active = 1'b0;

        if (!rst_n) begin
            // Keep the pipe frozen and clean while reset is held.
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            state_d     = IDLE;
            cnt_d       = 3'd0;
        end else if (bus.branch_taken_ex) begin
            // Wrong-path instructions in IF/ID and ID must die; any pending stall is moot.
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            state_d     = IDLE;
            cnt_d       = 3'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hazard) begin
                        pc_enable    = 1'b0;
                        ifid_enable  = 1'b0;
                        idex_bubble  = 1'b1;
                        stall_active = 1'b1;
                        // First stall cycle is this one; STALL covers the remainder.
                        if (LOAD_LAT > 1) begin
                            state_d = STALL;
                            cnt_d   = 3'(LOAD_LAT - 1);
                        end
                    end
                end
                STALL: begin
                    // EX holds a bubble here, so the hazard inputs carry no new information.
                    pc_enable    = 1'b0;
                    ifid_enable  = 1'b0;
                    idex_bubble  = 1'b1;
                    stall_active = 1'b1;
                    cnt_d        = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // State and remaining-stall counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall-cycle performance counter.
    hazard_perf_counter #(
        .PERF_W (PERF_W)
    ) u_perf (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_active),
        .clr   (bus.perf_clr),
        .count (bus.stall_cycles)
    );

    // Drive the control outputs onto the bundle.
    always_comb begin
        bus.pc_enable    = pc_enable;
        bus.ifid_enable  = ifid_enable;
        bus.idex_bubble  = idex_bubble;
        bus.ifid_flush   = ifid_flush;
        bus.stall_active = stall_active;
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: LOAD_LAT=1 (narrow perf counter) and LOAD_LAT=3 instances.
// Latency: checks combinational outputs half a cycle after each drive.
// Backpressure: n/a.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1 = 1'b0;
    logic rst3 = 1'b0;

    hazard_stall_ctrl_if #(.INSTR_W(16), .PERF_W(4))  if1 ();
    hazard_stall_ctrl_if #(.INSTR_W(16), .PERF_W(16)) if3 ();

    hazard_stall_ctrl #(.LOAD_LAT(1), .PERF_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst1),
        .bus   (if1)
    );

    hazard_stall_ctrl #(.LOAD_LAT(3), .PERF_W(16)) dut3 (
        .clk   (clk),
        .rst_n (rst3),
        .bus   (if3)
    );

    // {pc_enable, ifid_enable, idex_bubble, ifid_flush, stall_active}
    localparam logic [4:0] RUN = 5'b11000;
    localparam logic [4:0] STL = 5'b00101;
    localparam logic [4:0] BRF = 5'b11110;
    localparam logic [4:0] RST = 5'b00110;

    localparam logic [15:0] LD_R3   = 16'hB312;
    localparam logic [15:0] USE_RS3 = 16'h2436;
    localparam logic [15:0] USE_RT3 = 16'h2123;
    localparam logic [15:0] LD_R0   = 16'hB012;
    localparam logic [15:0] USE_R0  = 16'h2106;

    typedef struct {
        string       tag;
        int          sel;
        logic [4:0]  outs;
        logic [15:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   nvec = 0;
    int   nerr = 0;

    // Pop the oldest expectation and compare it with what the selected DUT shows now.
    task automatic check_head();
        exp_t        e;
        logic [4:0]  got_o;
        logic [15:0] got_c;
        e = sbq.pop_front();
        if (e.sel == 1) begin
            got_o = {if1.pc_enable, if1.ifid_enable, if1.idex_bubble, if1.ifid_flush, if1.stall_active};
            got_c = {12'd0, if1.stall_cycles};
        end else begin
            got_o = {if3.pc_enable, if3.ifid_enable, if3.idex_bubble, if3.ifid_flush, if3.stall_active};
            got_c = if3.stall_cycles;
        end
        nvec++;
        assert (got_o === e.outs) else begin
            nerr++;
            $error("FAIL %s ctl got=%b exp=%b", e.tag, got_o, e.outs);
        end
        nvec++;
        assert (got_c === e.cnt) else begin
            nerr++;
            $error("FAIL %s stall_cycles got=%h exp=%h", e.tag, got_c, e.cnt);
        end
    endtask

    // Drive one cycle of inputs just after the edge, queue the expectation, check at the falling edge.
    task automatic step(input string tag, input int sel, input logic r,
                        input logic [15:0] ex, input logic exv,
                        input logic [15:0] id, input logic idv,
                        input logic br, input logic clr,
                        input logic [4:0] outs, input logic [15:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        if (sel == 1) begin
            rst1 = r;
            if1.instr_ex = ex;  if1.ex_valid = exv;
            if1.instr_id = id;  if1.id_valid = idv;
            if1.branch_taken_ex = br; if1.perf_clr = clr;
        end else begin
            rst3 = r;
            if3.instr_ex = ex;  if3.ex_valid = exv;
            if3.instr_id = id;  if3.id_valid = idv;
            if3.branch_taken_ex = br; if3.perf_clr = clr;
        end
        e.tag = tag; e.sel = sel; e.outs = outs; e.cnt = cnt;
        sbq.push_back(e);
        @(negedge clk);
        check_head();
    endtask

    initial begin
        if1.instr_ex = '0; if1.ex_valid = 1'b0; if1.instr_id = '0; if1.id_valid = 1'b0;
        if1.branch_taken_ex = 1'b0; if1.perf_clr = 1'b0;
        if3.instr_ex = '0; if3.ex_valid = 1'b0; if3.instr_id = '0; if3.id_valid = 1'b0;
        if3.branch_taken_ex = 1'b0; if3.perf_clr = 1'b0;

        // LOAD_LAT=1, PERF_W=4
        step("a_rst0",     1, 1'b0, LD_R3, 1'b1, USE_RS3, 1'b1, 1'b0, 1'b0, RST, 16'd0);
        step("a_rst1",     1, 1'b0, 16'h0, 1'b0, 16'h0,   1'b0, 1'b0, 1'b0, RST, 16'd0);
        step("a_idle",     1, 1'b1, 16'h0, 1'b0, 16'h0,   1'b0, 1'b0, 1'b0, RUN, 16'd0);
        step("a_haz_rs",   1, 1'b1, LD_R3, 1'b1, USE_RS3, 1'b1, 1'b0, 1'b0, STL, 16'd0);
        step("a_after",    1, 1'b1, 16'h0, 1'b0, USE_RS3, 1'b1, 1'b0, 1'b0, RUN, 16'd1);
        step("a_zero_reg", 1, 1'b1, LD_R0, 1'b1, USE_R0,  1'b1, 1'b0, 1'b0, RUN, 16'd1);
        step("a_id_inval", 1, 1'b1, LD_R3, 1'b1, USE_RS3, 1'b0, 1'b0, 1'b0, RUN, 16'd1);
        step("a_haz_rt",   1, 1'b1, LD_R3, 1'b1, USE_RT3, 1'b1, 1'b0, 1'b0, STL, 16'd1);
        // Back-to-back hazards drive the 4-bit counter into saturation.
        for (int k = 2; k <= 17; k++) begin
            step($sformatf("a_sat%0d", k), 1, 1'b1, LD_R3, 1'b1, USE_RS3, 1'b1, 1'b0, 1'b0,
                 STL, (k > 15) ? 16'd15 : 16'(k));
        end
        step("a_clr_stl",  1, 1'b1, LD_R3, 1'b1, USE_RS3, 1'b1, 1'b0, 1'b1, STL, 16'd15);
        step("a_clr_won",  1, 1'b1, 16'h0, 1'b0, 16'h0,   1'b0, 1'b0, 1'b0, RUN, 16'd0);
        step("a_br_haz",   1, 1'b1, LD_R3, 1'b1, USE_RS3, 1'b1, 1'b1, 1'b0, BRF, 16'd0);
        step("a_br_nocnt", 1, 1'b1, 16'h0, 1'b0, 16'h0,   1'b0, 1'b0, 1'b0, RUN, 16'd0);

        // LOAD_LAT=3, PERF_W=16
        step("b_idle",     3, 1'b1, 16'h0, 1'b0, 16'h0,   1'b0, 1'b0, 1'b0, RUN, 16'd0);
        step("b_stl1",     3, 1'b1, LD_R3, 1'b1, USE_RS3, 1'b1, 1'b0, 1'b0, STL, 16'd0);
        step("b_stl2",     3, 1'b1, LD_R3, 1'b1, USE_RS3, 1'b1, 1'b0, 1'b0, STL, 16'd1);
        step("b_stl3",     3, 1'b1, LD_R3, 1'b1, USE_RS3, 1'b1, 1'b0, 1'b0, STL, 16'd2);
        step("b_release",  3, 1'b1, 16'h0, 1'b0, USE_RS3, 1'b1, 1'b0, 1'b1, RUN, 16'd3);
        step("b_ab_stl1",  3, 1'b1, LD_R3, 1'b1, USE_RS3, 1'b1, 1'b0, 1'b0, STL, 16'd0);
        step("b_ab_br",    3, 1'b1, LD_R3, 1'b1, USE_RS3, 1'b1, 1'b1, 1'b0, BRF, 16'd1);
        step("b_ab_idle",  3, 1'b1, 16'h0, 1'b0, 16'h0,   1'b0, 1'b0, 1'b0, RUN, 16'd1);
        step("b_rs_stl1",  3, 1'b1, LD_R3, 1'b1, USE_RS3, 1'b1, 1'b0, 1'b0, STL, 16'd1);
        step("b_rs_rst",   3, 1'b0, LD_R3, 1'b1, USE_RS3, 1'b1, 1'b0, 1'b0, RST, 16'd2);
        step("b_rs_after", 3, 1'b1, 16'h0, 1'b0, USE_RS3, 1'b1, 1'b0, 1'b0, RUN, 16'd0);
        step("b_re_stl1",  3, 1'b1, LD_R3, 1'b1, USE_RS3, 1'b1, 1'b0, 1'b0, STL, 16'd0);
        step("b_re_stl2",  3, 1'b1, 16'h0, 1'b0, USE_RS3, 1'b1, 1'b0, 1'b0, STL, 16'd1);
        step("b_re_stl3",  3, 1'b1, 16'h0, 1'b0, USE_RS3, 1'b1, 1'b0, 1'b0, STL, 16'd2);
        step("b_re_done",  3, 1'b1, 16'h0, 1'b0, USE_RS3, 1'b1, 1'b0, 1'b0, RUN, 16'd3);

        nvec++;
        assert (sbq.size() == 0) else begin
            nerr++;
            $error("FAIL sb_drain left=%0d exp=0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
